// File: rtl/store_word_merge_pkg.sv
// Shared encodings for the load/store sub-word units: store types and
// the store-merge FSM states.
package store_word_merge_pkg;

  typedef enum logic [1:0] {
    STORE_SB  = 2'd0,
    STORE_SH  = 2'd1,
    STORE_SW  = 2'd2,
    STORE_ILL = 2'd3
  } store_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/store_word_merge_lane.sv
// Combinational lane merge: overlays the low byte/half of wdata onto the
// word read back from memory. No sign or zero extension takes place.
module store_lane_merge
  import store_word_merge_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [15:0]       wdata,
  input  logic [1:0]        store_type,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] new_word
);

  always_comb begin
    new_word = old_word;
    case (store_type_e'(store_type))
      STORE_SB: new_word[{offset, 3'b000} +: 8] = wdata[7:0];
      // Halfword alignment is checked at accept, so only offset[1] matters
      STORE_SH: begin
        if (offset[1]) new_word[31:16] = wdata;
        else           new_word[15:0]  = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_word_merge.sv
// SB/SH/SW store unit for a word-only data memory; sub-word stores are
// done as read-modify-write, misaligned/illegal requests raise an exception.
module store_word_merge
  import store_word_merge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wack,
  output logic              done,
  output logic              exc_misalign
);

  state_e            state, state_nxt;
  store_type_e       req_type;
  store_type_e       type_p0;
  logic [1:0]        off_p0;
  logic [15:0]       half_p0;
  logic              accept;
  logic              bad_req;
  logic [DATA_W-1:0] merged;

  assign req_type = store_type_e'(store_type);
  assign accept   = req_valid && (state == ST_IDLE);

  always_comb begin
    case (req_type)
      STORE_SB: bad_req = 1'b0;
      STORE_SH: bad_req = addr[0];
      STORE_SW: bad_req = (addr[1:0] != 2'b00);
      default:  bad_req = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && !bad_req)
          state_nxt = (req_type == STORE_SW) ? ST_WRITE : ST_READ;
      end
      ST_READ:  if (mem_rvalid) state_nxt = ST_WRITE;
      ST_WRITE: if (mem_wack)   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    mem_re    = (state == ST_READ);
    mem_we    = (state == ST_WRITE);
  end

  // Accept stage: request copy held for the merge, no reset needed
  always_ff @(posedge clk) begin
    if (accept && !bad_req) begin
      type_p0 <= req_type;
      off_p0  <= addr[1:0];
      half_p0 <= wdata[15:0];
    end
  end

  store_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word   (mem_rdata),
    .wdata      (half_p0),
    .store_type (type_p0),
    .offset     (off_p0),
    .new_word   (merged)
  );

  // Memory-side registers and completion/exception pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr     <= '0;
      mem_wdata    <= '0;
      done         <= 1'b0;
      exc_misalign <= 1'b0;
    end else begin
      done         <= (state == ST_WRITE) && mem_wack;
      exc_misalign <= accept && bad_req;
      if (accept && !bad_req) begin
        mem_addr <= {addr[ADDR_W-1:2], 2'b00};
        if (req_type == STORE_SW) mem_wdata <= wdata;
      end
      if ((state == ST_READ) && mem_rvalid) mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_store_word_merge.sv
// Directed bench for store_word_merge: a scoreboard of expected memory
// writes/exceptions checked by a monitor, plus latency/handshake checks.
module tb_store_word_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_wack;
  logic        done;
  logic        exc_misalign;

  typedef struct {
    bit          is_exc;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          rd_delay = 1;
  int          wr_delay = 1;
  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  logic [31:0] mem_word = 32'h0;
  logic        entry_done;

  always #5 clk = ~clk;

  store_word_merge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .store_type   (store_type),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_wack     (mem_wack),
    .done         (done),
    .exc_misalign (exc_misalign)
  );

  task automatic check(input string name, input string what,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s actual=%0h required=%0h", name, what, act, exp);
    end
  endtask

  // Memory responder: pulses rvalid/wack N cycles after the request asserts
  initial begin
    mem_rvalid = 1'b0;
    mem_wack   = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_wack   = 1'b0;
      if (mem_re) begin
        rd_cnt++;
        if (rd_cnt == rd_delay + 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word;
          rd_cnt     = 0;
        end
      end else rd_cnt = 0;
      if (mem_we) begin
        wr_cnt++;
        if (wr_cnt == wr_delay + 1) begin
          mem_wack = 1'b1;
          wr_cnt   = 0;
        end
      end else wr_cnt = 0;
    end
  end

  // Monitor: pops the scoreboard on every write handshake or exception
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("mon", "re_we_both", {63'd0, mem_re & mem_we}, 64'd0);
      if (mem_we && mem_wack) begin
        if (exp_q.size() == 0) check("mon", "unexpected_write", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("mon", "write_vs_exc", {63'd0, e.is_exc}, 64'd0);
          check("mon", "wr_addr", {32'd0, mem_addr}, {32'd0, e.addr});
          check("mon", "wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
        end
      end
      if (exc_misalign) begin
        if (exp_q.size() == 0) check("mon", "unexpected_exc", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("mon", "exc_vs_write", {63'd0, e.is_exc}, 64'd1);
        end
      end
    end
  end

  // Issues one store starting at a negedge; returns at the done/exc negedge
  task automatic do_store(input string name, input logic [1:0] ty,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdata, input bit is_exc,
                          input logic [31:0] exp_data, input int exp_lat);
    int n;
    int lat;
    bit saw_re;
    bit saw_idle;
    mem_word = rdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, "ready_timeout", {63'd0, req_ready}, 64'd1);
    entry_done = done;
    exp_q.push_back('{is_exc, {a[31:2], 2'b00}, exp_data});
    req_valid  = 1'b1;
    store_type = ty;
    addr       = a;
    wdata      = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    store_type = 2'($urandom);
    addr       = $urandom;
    wdata      = $urandom;
    lat = 1;
    saw_re = 1'b0;
    saw_idle = 1'b0;
    while (!(done || exc_misalign) && lat < 60) begin
      if (mem_re) saw_re = 1'b1;
      if (!busy)  saw_idle = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (is_exc) begin
      check(name, "exc_lat", lat, 1);
      check(name, "exc_pulse", {62'd0, exc_misalign, done}, 64'd2);
      check(name, "exc_mem", {62'd0, mem_re, mem_we}, 64'd0);
      check(name, "exc_ready", {63'd0, req_ready}, 64'd1);
    end else begin
      check(name, "done_lat", lat, exp_lat);
      check(name, "done_pulse", {62'd0, done, exc_misalign}, 64'd2);
      check(name, "busy_held", {63'd0, saw_idle}, 64'd0);
      if (ty == 2'd2) check(name, "sw_no_read", {63'd0, saw_re}, 64'd0);
    end
  endtask

  initial begin
    bit bad;
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit flag;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    store_type = 2'd0;
    addr       = 32'h0;
    wdata      = 32'h0;
    repeat (3) @(negedge clk);
    check("reset", "ctrl", {58'd0, mem_re, mem_we, done, exc_misalign, busy, req_ready},
          64'd1);
    check("reset", "mem_regs", {mem_addr, mem_wdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_store("sw_100", 2'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF, 3);
    do_store("sb_203", 2'd0, 32'h203, 32'h000000AB, 32'h11223344, 0, 32'hAB223344, 5);
    do_store("sb_200", 2'd0, 32'h200, 32'h000000AB, 32'h11223344, 0, 32'h112233AB, 5);
    do_store("sb_201", 2'd0, 32'h201, 32'h123456AB, 32'h11223344, 0, 32'h1122AB44, 5);
    do_store("sb_202", 2'd0, 32'h202, 32'h000000AB, 32'h11223344, 0, 32'h11AB3344, 5);
    do_store("sh_302", 2'd1, 32'h302, 32'h0000CAFE, 32'h11223344, 0, 32'hCAFE3344, 5);
    rd_delay = 4;
    do_store("sh_300_slow", 2'd1, 32'h300, 32'h5555CAFE, 32'h11223344, 0, 32'h1122CAFE, 8);
    rd_delay = 1;

    do_store("sh_301_mis", 2'd1, 32'h301, 32'h0, 32'h0, 1, 32'h0, 0);
    do_store("sw_102_mis", 2'd2, 32'h102, 32'h0, 32'h0, 1, 32'h0, 0);
    do_store("ty3_ill", 2'd3, 32'h400, 32'h0, 32'h0, 1, 32'h0, 0);
    flag = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || exc_misalign || mem_re || mem_we) flag = 1'b1;
    end
    check("exc_quiet", "no_activity", {63'd0, flag}, 64'd0);

    // Reset while a read is outstanding
    rd_delay   = 10;
    mem_word   = 32'hFFFFFFFF;
    req_valid  = 1'b1;
    store_type = 2'd0;
    addr       = 32'h600;
    wdata      = 32'h5A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid", "in_read", {63'd0, mem_re}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid", "aborted", {59'd0, mem_re, mem_we, busy, done, exc_misalign}, 64'd0);
    rst_n = 1'b1;
    flag = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || exc_misalign || busy) flag = 1'b1;
    end
    check("rst_mid", "stays_idle", {63'd0, flag}, 64'd0);
    rd_delay = 1;
    do_store("sw_0_after_rst", 2'd2, 32'h0, 32'h0BADF00D, 32'h0, 0, 32'h0BADF00D, 3);

    // Back-to-back with a stalled write acknowledge
    wr_delay = 3;
    do_store("b2b_sb", 2'd0, 32'h503, 32'h00000077, 32'hA0B0C0D0, 0, 32'h77B0C0D0, 7);
    do_store("b2b_sw", 2'd2, 32'h504, 32'h12345678, 32'h0, 0, 32'h12345678, 5);
    check("b2b_sw", "accept_on_done", {63'd0, entry_done}, 64'd1);
    wr_delay = 1;

    repeat (3) @(negedge clk);
    check("end", "queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
